// File: rtl/sample_uart_pkg.sv
// Shared definitions for the sample UART transmitter: FSM states, byte tags
// and the helper that turns one 18-bit sample into its three tagged bytes.
package sample_uart_pkg;

   localparam int SAMPLE_W = 18;

   localparam logic [1:0] TAG_HI  = 2'b10;
   localparam logic [1:0] TAG_MID = 2'b01;
   localparam logic [1:0] TAG_LO  = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txState_e;

   // The 2-bit tags let the host find byte0 again after losing sync.
   function automatic logic [7:0] sampleByte(input logic [SAMPLE_W-1:0] s,
                                             input logic [1:0]          idx);
      case (idx)
         2'd0:    return {TAG_HI,  s[17:12]};
         2'd1:    return {TAG_MID, s[11:6]};
         default: return {TAG_LO,  s[5:0]};
      endcase
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through FIFO. A write into a full FIFO is still
// accepted when a read happens on the same edge.
module sample_fifo #(
   parameter int WIDTH      = 18,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrEn_i,
   input  logic             rdEn_i,
   input  logic [WIDTH-1:0] wrData_i,
   output logic [WIDTH-1:0] rdData_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr_q;
   logic [DEPTH_LOG2-1:0] rdPtr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  wrOk;
   logic                  rdOk;

   assign full_o   = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign rdData_o = mem_q[rdPtr_q];
   assign wrOk     = wrEn_i & (~full_o | rdEn_i);
   assign rdOk     = rdEn_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (wrOk) begin
         mem_q[wrPtr_q] <= wrData_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (wrOk) wrPtr_q <= wrPtr_q + 1'b1;
         if (rdOk) rdPtr_q <= rdPtr_q + 1'b1;
         case ({wrOk, rdOk})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sample_uart_tx.sv
// Buffers 18-bit result samples and sends each as three tagged bytes on an
// 8N1 UART line, back to back with no idle gap while samples are queued.
module sample_uart_tx
   import sample_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT    = 868,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sampleIn,
   input  logic                sampleValid,
   output logic                txd,
   output logic                busy,
   output logic                overflow
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   txState_e            state_q, state_d;
   logic [BAUD_W-1:0]   baudCnt_q, baudCnt_d;
   logic [2:0]          bitIdx_q, bitIdx_d;
   logic [1:0]          byteIdx_q, byteIdx_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                txd_q, txd_d;
   logic                busy_q;
   logic                overflow_q;

   logic                pop;
   logic                fifoFull;
   logic                fifoEmpty;
   logic [SAMPLE_W-1:0] fifoDout;
   logic                wrAccepted;
   logic                baudDone;
   logic [7:0]          curByte;
   logic [2:0]          nextBit;

   sample_fifo #(
      .WIDTH      (SAMPLE_W),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wrEn_i   (sampleValid),
      .rdEn_i   (pop),
      .wrData_i (sampleIn),
      .rdData_o (fifoDout),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty)
   );

   assign baudDone   = (baudCnt_q == BAUD_LAST);
   assign curByte    = sampleByte(sample_q, byteIdx_q);
   assign nextBit    = bitIdx_q + 3'd1;
   assign wrAccepted = sampleValid & (~fifoFull | pop);

   // txd is computed one edge ahead so the line itself comes straight off a flop.
   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudDone ? '0 : baudCnt_q + BAUD_W'(1);
      bitIdx_d  = bitIdx_q;
      byteIdx_d = byteIdx_q;
      sample_d  = sample_q;
      txd_d     = txd_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            baudCnt_d = '0;
            txd_d     = 1'b1;
            if (!fifoEmpty) begin
               pop       = 1'b1;
               sample_d  = fifoDout;
               byteIdx_d = 2'd0;
               state_d   = START;
               txd_d     = 1'b0;
            end
         end
         START: begin
            if (baudDone) begin
               state_d  = DATA;
               bitIdx_d = 3'd0;
               txd_d    = curByte[0];
            end
         end
         DATA: begin
            if (baudDone) begin
               if (bitIdx_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bitIdx_d = nextBit;
                  txd_d    = curByte[nextBit];
               end
            end
         end
         STOP: begin
            if (baudDone) begin
               if (byteIdx_q != 2'd2) begin
                  byteIdx_d = byteIdx_q + 2'd1;
                  state_d   = START;
                  txd_d     = 1'b0;
               end else if (!fifoEmpty) begin
                  pop       = 1'b1;
                  sample_d  = fifoDout;
                  byteIdx_d = 2'd0;
                  state_d   = START;
                  txd_d     = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // The FIFO can only be non-empty in IDLE for the one cycle after a write,
   // so the next busy value is "leaving IDLE or a write just landed".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baudCnt_q  <= '0;
         bitIdx_q   <= '0;
         byteIdx_q  <= '0;
         sample_q   <= '0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitIdx_q  <= bitIdx_d;
         byteIdx_q <= byteIdx_d;
         sample_q  <= sample_d;
         txd_q     <= txd_d;
         busy_q    <= (state_d != IDLE) | wrAccepted;
         if (sampleValid && fifoFull && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign txd      = txd_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
- Output end of the filter/FFT datapath: takes 18-bit result samples presented as a one-cycle valid strobe and buffers them in a small FIFO.
- Splits each sample into three tagged bytes and serialises them on an 8N1 UART transmit line to the host.
- Absorbs bursts of strobes; the UART drains them at the baud rate.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- FIFO_DEPTH_LOG2, 3, sample FIFO holds 2**FIFO_DEPTH_LOG2 = 8 samples.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sampleIn  in  18  sample from the filter/FFT stage; meaningful only when sampleValid=1.
- sampleValid  in  1  one-cycle strobe, same meaning as the filter's dataReady; back-to-back strobes allowed.
- txd  out  1  UART serial output, idle high, registered.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  out  1  sticky; set when a strobe arrives with the FIFO full.

Behaviour:
- Reset (async, rst=1): txd=1, busy=0, overflow=0, FIFO emptied, FSM to IDLE, bit/byte counters cleared. Reset mid-frame aborts the frame immediately; no partial byte is completed.
- FIFO write: on an edge with sampleValid=1 and FIFO not full, sampleIn is written.
- Write when full: the sample is dropped, FIFO contents are unchanged, and overflow is set to 1 and held until reset.
- Same-edge write and pop with FIFO full: the pop frees a slot, so the write is accepted and overflow is not set.
- Byte format:
  - byte0 = {2'b10, s[17:12]}
  - byte1 = {2'b01, s[11:6]}
  - byte2 = {2'b00, s[5:0]}
  - Sent in the order byte0, byte1, byte2. The tag bits let the host resynchronise.
- UART frame: 8N1, LSB first. Each bit lasts exactly CLKS_PER_BIT clocks: start (0), d0..d7, stop (1).
- FSM states:
  - IDLE: txd=1. If the FIFO is non-empty: pop it, latch the sample, byteIdx=0, go to START. txd is driven 0 on that same edge, so the start bit begins on the first edge after the write edge when the block is idle and the FIFO is empty.
  - START: hold txd=0 for CLKS_PER_BIT clocks, then go to DATA with bitIdx=0.
  - DATA: txd = byte[bitIdx] for CLKS_PER_BIT clocks per bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT clocks. Then:
    - if byteIdx<2: byteIdx++ and go to START (no idle gap between bytes);
    - else if the FIFO is non-empty: pop it and go to START (no gap between samples);
    - else go to IDLE.
- Timing:
  - One sample = 30 bit times = 30*CLKS_PER_BIT clocks, start-bit edge to the end of the stop bit.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; its width is clog2(CLKS_PER_BIT).
- busy = (state != IDLE) | fifo_not_empty, registered. It deasserts on the edge the FSM returns to IDLE with the FIFO empty.
- FIFO pointers: wrap modulo the depth. full/empty come from a FIFO_DEPTH_LOG2+1 bit occupancy count.
- No backpressure is exported; the producer never stalls.

Decomposition:
- Shared package (sample_uart_pkg):
  - state encoding: IDLE, START, DATA, STOP;
  - byte tag constants TAG_HI=2'b10, TAG_MID=2'b01, TAG_LO=2'b00;
  - SAMPLE_W=18.
- Sub-module sample_fifo: synchronous single-clock FIFO with parameters WIDTH and DEPTH_LOG2. Ports: write enable, read enable, data in, data out, full, empty.
- The top level holds the FSM, the baud counter, bit/byte indices and overflow.

Test Plan (CLKS_PER_BIT=4):
- Single sample 18'h2A5C3, one strobe, FIFO empty → txd falls on the next edge, then bytes 0xAA, 0x57, 0x03 LSB-first, each framed 0/1. Frame is 120 clocks, then txd=1 and busy=0; overflow stays 0.
- Two back-to-back strobes 18'h3FFFF, 18'h00000 → bytes BF,7F,3F,80,40,00 with no idle gap; 240 clocks of activity.
- Fill test: 10 strobes on consecutive cycles while idle → the first is popped immediately and 8 more are buffered, so 9 samples are transmitted in order. The 10th is dropped and overflow=1 from the edge after it, held through the drain.
- Simultaneous pop and write with FIFO full at the STOP→START boundary → write accepted, overflow remains 0, all samples are transmitted.
- Async reset asserted mid-DATA of byte1 → txd=1, busy=0 and overflow=0 immediately without waiting for an edge. After release, a new strobe of 18'h00001 sends 80,40,01 cleanly.
- Idle check: no strobes for 1000 clocks after reset → txd held at 1 and busy=0 throughout.
